// File: rtl/snake_body_pkg.sv
// Shared encodings for the snake movement engine and the game-state FSM.
package snake_body_pkg;

  // Game state as driven by the FSM.
  typedef enum logic [1:0] {
    GsRunning = 2'b00,
    GsDie     = 2'b01,
    GsInitial = 2'b10
  } game_state_e;

  // Heading encoding; opposite headings differ only in bit 1.
  typedef enum logic [1:0] {
    DirRight = 2'd0,
    DirUp    = 2'd1,
    DirLeft  = 2'd2,
    DirDown  = 2'd3
  } dir_e;

  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_dir_ctrl.sv
// Heading control: button priority, reverse rejection, pending and committed heading.
module snake_dir_ctrl
  import snake_body_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic run,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic commit,
  output dir_e next_dir
);

  dir_e next_dir_q, next_dir_d;
  dir_e cur_dir_q, cur_dir_d;
  dir_e req;
  logic req_valid;
  dir_e ref_dir;

  // Fixed-priority button decode: up > down > left > right.
  always_comb begin
    req       = DirRight;
    req_valid = 1'b1;
    if (up) begin
      req = DirUp;
    end else if (down) begin
      req = DirDown;
    end else if (left) begin
      req = DirLeft;
    end else if (right) begin
      req = DirRight;
    end else begin
      req_valid = 1'b0;
    end
  end

  // Accept a request unless it reverses the heading actually being moved along.
  always_comb begin
    next_dir_d = next_dir_q;
    cur_dir_d  = cur_dir_q;
    // On the commit cycle the pending heading becomes the moving heading at the same edge,
    // so a request arriving then must be judged against it.
    ref_dir    = commit ? next_dir_q : cur_dir_q;
    if (init) begin
      next_dir_d = DirRight;
      cur_dir_d  = DirRight;
    end else begin
      if (commit) begin
        cur_dir_d = next_dir_q;
      end
      if (run && req_valid && (req != dir_opposite(ref_dir))) begin
        next_dir_d = req;
      end
    end
  end

  // Heading registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_dir_q <= DirRight;
      cur_dir_q  <= DirRight;
    end else begin
      next_dir_q <= next_dir_d;
      cur_dir_q  <= cur_dir_d;
    end
  end

  assign next_dir = next_dir_q;

endmodule

// File: rtl/snake_body.sv
// Snake movement engine: segment storage, tick-paced stepping, collision flags, cell query.
module snake_body
  import snake_body_pkg::*;
#(
  parameter int unsigned GRID_W      = 40,
  parameter int unsigned GRID_H      = 30,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned INIT_LEN    = 3,
  parameter int unsigned TICK_CYCLES = 12_500_000,
  localparam int unsigned X_W        = $clog2(GRID_W),
  localparam int unsigned Y_W        = $clog2(GRID_H),
  localparam int unsigned L_W        = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     game_state,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           grow,
  input  logic [X_W-1:0] query_x,
  input  logic [Y_W-1:0] query_y,
  output logic           query_hit,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [L_W-1:0] length,
  output logic           step,
  output logic           hit_boundary,
  output logic           hit_self
);

  localparam int unsigned TC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TC_W-1:0] TickLast = TC_W'(TICK_CYCLES - 1);
  localparam logic [X_W-1:0]  XMax     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]  YMax     = Y_W'(GRID_H - 1);
  localparam logic [L_W-1:0]  LenInit  = L_W'(INIT_LEN);
  localparam logic [L_W-1:0]  LenMax   = L_W'(MAX_LEN);

  function automatic logic [X_W-1:0] init_x(input int unsigned i);
    return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
  endfunction

  localparam logic [Y_W-1:0] InitY = Y_W'(GRID_H / 2);

  logic [X_W-1:0]  seg_x_q [MAX_LEN];
  logic [X_W-1:0]  seg_x_d [MAX_LEN];
  logic [Y_W-1:0]  seg_y_q [MAX_LEN];
  logic [Y_W-1:0]  seg_y_d [MAX_LEN];
  logic [L_W-1:0]  len_q, len_d;
  logic [TC_W-1:0] tick_q, tick_d;
  logic            grow_pend_q, grow_pend_d;
  logic            step_q, step_d;
  logic            hit_b_q, hit_b_d;
  logic            hit_s_q, hit_s_d;

  logic            is_init, is_run, move;
  dir_e            next_dir;
  logic [X_W-1:0]  cand_x;
  logic [Y_W-1:0]  cand_y;
  logic            at_edge;
  logic            body_hit;
  logic [L_W-1:0]  chk_len;

  assign is_init = (game_state == GsInitial);
  assign is_run  = (game_state == GsRunning);

  snake_dir_ctrl u_dir_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init     (is_init),
    .run      (is_run),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .commit   (move),
    .next_dir (next_dir)
  );

  // Candidate head cell for the pending heading, flagging a move off the grid.
  always_comb begin
    cand_x  = seg_x_q[0];
    cand_y  = seg_y_q[0];
    at_edge = 1'b0;
    unique case (next_dir)
      DirRight: if (seg_x_q[0] == XMax) at_edge = 1'b1; else cand_x = seg_x_q[0] + 1'b1;
      DirLeft:  if (seg_x_q[0] == '0)   at_edge = 1'b1; else cand_x = seg_x_q[0] - 1'b1;
      DirUp:    if (seg_y_q[0] == '0)   at_edge = 1'b1; else cand_y = seg_y_q[0] - 1'b1;
      DirDown:  if (seg_y_q[0] == YMax) at_edge = 1'b1; else cand_y = seg_y_q[0] + 1'b1;
      default:  at_edge = 1'b0;
    endcase
  end

  // Body collision: the tail cell is free to enter unless this step also grows the snake.
  always_comb begin
    body_hit = 1'b0;
    chk_len  = grow_pend_q ? len_q : len_q - 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < chk_len) && (seg_x_q[i] == cand_x) && (seg_y_q[i] == cand_y)) begin
        body_hit = 1'b1;
      end
    end
  end

  // Renderer occupancy query over the active segments.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        query_hit = 1'b1;
      end
    end
  end

  // Next-state: initialise, pace the tick, evaluate and commit a step.
  always_comb begin
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    tick_d      = tick_q;
    grow_pend_d = grow_pend_q;
    step_d      = 1'b0;
    hit_b_d     = hit_b_q;
    hit_s_d     = hit_s_q;
    move        = 1'b0;
    if (is_init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = InitY;
      end
      len_d       = LenInit;
      tick_d      = '0;
      grow_pend_d = 1'b0;
      hit_b_d     = 1'b0;
      hit_s_d     = 1'b0;
    end else begin
      grow_pend_d = grow_pend_q | grow;
      if (is_run) begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          if (at_edge) begin
            hit_b_d = 1'b1;
          end else if (body_hit) begin
            hit_s_d = 1'b1;
          end else begin
            move   = 1'b1;
            step_d = 1'b1;
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = cand_x;
            seg_y_d[0] = cand_y;
            if (grow_pend_q) begin
              if (len_q != LenMax) len_d = len_q + 1'b1;
              // A grow arriving on this same edge belongs to the next step.
              grow_pend_d = grow;
            end
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset to the initial snake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= InitY;
      end
      len_q       <= LenInit;
      tick_q      <= '0;
      grow_pend_q <= 1'b0;
      step_q      <= 1'b0;
      hit_b_q     <= 1'b0;
      hit_s_q     <= 1'b0;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      tick_q      <= tick_d;
      grow_pend_q <= grow_pend_d;
      step_q      <= step_d;
      hit_b_q     <= hit_b_d;
      hit_s_q     <= hit_s_d;
    end
  end

  assign head_x       = seg_x_q[0];
  assign head_y       = seg_y_q[0];
  assign length       = len_q;
  assign step         = step_q;
  assign hit_boundary = hit_b_q;
  assign hit_self     = hit_s_q;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body on an 8x6 grid with a 4-cycle tick.
module tb_snake_body;
  import snake_body_pkg::*;

  localparam int unsigned GW = 8;
  localparam int unsigned GH = 6;
  localparam int unsigned ML = 8;
  localparam int unsigned IL = 3;
  localparam int unsigned TC = 4;
  localparam int unsigned XW = $clog2(GW);
  localparam int unsigned YW = $clog2(GH);
  localparam int unsigned LW = $clog2(ML + 1);

  localparam logic [3:0] BN = 4'b0000;
  localparam logic [3:0] BU = 4'b1000;
  localparam logic [3:0] BD = 4'b0100;
  localparam logic [3:0] BL = 4'b0010;
  localparam logic [3:0] BA = 4'b1111;

  logic          clk, rst;
  logic [1:0]    game_state;
  logic          up, down, left, right, grow;
  logic [XW-1:0] query_x;
  logic [YW-1:0] query_y;
  logic          query_hit;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          step, hit_boundary, hit_self;

  snake_body #(
    .GRID_W      (GW),
    .GRID_H      (GH),
    .MAX_LEN     (ML),
    .INIT_LEN    (IL),
    .TICK_CYCLES (TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .grow         (grow),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_hit    (query_hit),
    .head_x       (head_x),
    .head_y       (head_y),
    .length       (length),
    .step         (step),
    .hit_boundary (hit_boundary),
    .hit_self     (hit_self)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [LW-1:0] len;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every step pulse must match the next expected head/length.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        check("step_unexpected", 32'(step), 32'd0);
      end else begin
        e = sb.pop_front();
        check("step_head_x", 32'(head_x), 32'(e.x));
        check("step_head_y", 32'(head_y), 32'(e.y));
        check("step_length", 32'(length), 32'(e.len));
      end
    end
  end

  task automatic push(input int x, input int y, input int len);
    exp_t t;
    t.x   = XW'(x);
    t.y   = YW'(y);
    t.len = LW'(len);
    sb.push_back(t);
  endtask

  // One movement tick: buttons in cycles 1 and 2, grow in cycle 1 and/or on the step edge.
  task automatic tick(input logic [3:0] b1, input logic [3:0] b2, input logic g1,
                      input logic g4);
    {up, down, left, right} = b1;
    grow = g1;
    @(posedge clk); #1;
    {up, down, left, right} = b2;
    grow = 1'b0;
    @(posedge clk); #1;
    {up, down, left, right} = BN;
    @(posedge clk); #1;
    grow = g4;
    @(posedge clk); #1;
    grow = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic expect_state(input string tag, input int x, input int y, input int len,
                              input int hb, input int hs);
    check({tag, "_x"}, 32'(head_x), 32'(x));
    check({tag, "_y"}, 32'(head_y), 32'(y));
    check({tag, "_len"}, 32'(length), 32'(len));
    check({tag, "_hitb"}, 32'(hit_boundary), 32'(hb));
    check({tag, "_hits"}, 32'(hit_self), 32'(hs));
  endtask

  task automatic query(input string tag, input int x, input int y, input int exp);
    query_x = XW'(x);
    query_y = YW'(y);
    #1;
    check(tag, 32'(query_hit), 32'(exp));
  endtask

  task automatic enter_initial();
    game_state = GsInitial;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; game_state = GsInitial;
    {up, down, left, right} = BN; grow = 1'b0;
    query_x = '0; query_y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    expect_state("reset", 4, 3, 3, 0, 0);
    check("reset_step", 32'(step), 32'd0);
    query("reset_q_tail", 2, 3, 1);
    query("reset_q_beyond", 1, 3, 0);

    // Straight run into the right wall.
    game_state = GsRunning;
    push(5, 3, 3); push(6, 3, 3); push(7, 3, 3);
    repeat (3) tick(BN, BN, 1'b0, 1'b0);
    settle();
    drain("bnd_steps");
    tick(BN, BN, 1'b0, 1'b0);
    settle();
    expect_state("bnd_hit", 7, 3, 3, 1, 0);
    check("bnd_step", 32'(step), 32'd0);

    // Frozen in DIE, then re-initialised.
    game_state = GsDie;
    repeat (20) @(posedge clk);
    settle();
    expect_state("die_frozen", 7, 3, 3, 1, 0);
    enter_initial();
    settle();
    expect_state("restart", 4, 3, 3, 0, 0);

    // Reverse rejection, checked against the moving heading.
    game_state = GsRunning;
    push(5, 3, 3); tick(BL, BN, 1'b0, 1'b0);
    push(5, 2, 3); tick(BU, BL, 1'b0, 1'b0);
    push(4, 2, 3); tick(BL, BD, 1'b0, 1'b0);
    push(4, 1, 3); tick(BA, BN, 1'b0, 1'b0);
    settle();
    drain("rev_steps");

    // Growth, grow on the step edge, saturation, then the top wall.
    enter_initial();
    game_state = GsRunning;
    push(5, 3, 4); tick(BN, BN, 1'b1, 1'b0);
    settle();
    query("grow_q_oldtail", 2, 3, 1);
    query("grow_q_free", 1, 3, 0);
    query("grow_q_head", 5, 3, 1);
    push(6, 3, 4); tick(BN, BN, 1'b0, 1'b1);
    push(7, 3, 5); tick(BN, BN, 1'b0, 1'b0);
    push(7, 2, 6); tick(BU, BN, 1'b1, 1'b0);
    push(7, 1, 7); tick(BN, BN, 1'b1, 1'b0);
    push(7, 0, 8); tick(BN, BN, 1'b1, 1'b0);
    push(6, 0, 8); tick(BL, BN, 1'b1, 1'b0);
    settle();
    drain("grow_steps");
    tick(BU, BN, 1'b0, 1'b0);
    settle();
    expect_state("top_hit", 6, 0, 8, 1, 0);
    game_state = GsDie;

    // Self collision with length 5.
    enter_initial();
    game_state = GsRunning;
    push(5, 3, 4); tick(BN, BN, 1'b1, 1'b0);
    push(6, 3, 5); tick(BN, BN, 1'b1, 1'b0);
    push(6, 2, 5); tick(BU, BN, 1'b0, 1'b0);
    push(5, 2, 5); tick(BL, BN, 1'b0, 1'b0);
    tick(BD, BN, 1'b0, 1'b0);
    settle();
    expect_state("self_hit", 5, 2, 5, 0, 1);
    drain("self_steps");
    game_state = GsDie;

    // Tail chase at length 4 is legal.
    enter_initial();
    game_state = GsRunning;
    push(5, 3, 4); tick(BN, BN, 1'b1, 1'b0);
    push(5, 2, 4); tick(BU, BN, 1'b0, 1'b0);
    push(4, 2, 4); tick(BL, BN, 1'b0, 1'b0);
    push(4, 3, 4); tick(BD, BN, 1'b0, 1'b0);
    settle();
    expect_state("chase", 4, 3, 4, 0, 0);
    drain("chase_steps");

    // Same chase with a grow pending: the tail stays, so it is a hit.
    enter_initial();
    game_state = GsRunning;
    push(5, 3, 4); tick(BN, BN, 1'b1, 1'b0);
    push(5, 2, 4); tick(BU, BN, 1'b0, 1'b0);
    push(4, 2, 4); tick(BL, BN, 1'b0, 1'b1);
    tick(BD, BN, 1'b0, 1'b0);
    settle();
    expect_state("chase_grow", 4, 2, 4, 0, 1);
    drain("chase_grow_steps");
    game_state = GsDie;

    // Reset on the step edge wins.
    enter_initial();
    game_state = GsRunning;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    game_state = GsInitial;
    settle();
    expect_state("rst_mid", 4, 3, 3, 0, 0);
    check("rst_mid_step", 32'(step), 32'd0);
    repeat (2) @(posedge clk);
    settle();
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
